// File: rtl/bcd_counter_multi.sv
// Multi-digit BCD up/down counter with parallel load, digit validation and
// selectable wrap/saturate behaviour at the terminal value.
module bcd_counter_multi #(
  parameter int unsigned DIGITS   = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  TC,
  output logic                  load_err
);

  logic [4*DIGITS-1:0] r_q;
  logic                r_load_err;

  logic [4*DIGITS-1:0] w_step;
  logic [4*DIGITS-1:0] w_load_san;
  logic                w_load_bad;
  logic                w_carry;
  logic [3:0]          w_dig;
  logic                w_all9;
  logic                w_all0;
  logic                w_at_term;

  // One-step increment/decrement with ripple carry/borrow across all digits.
  // Wrapping at the terminal value falls out of the chain naturally.
  always_comb begin
    w_step  = r_q;
    w_carry = 1'b1;
    w_dig   = 4'd0;
    w_all9  = 1'b1;
    w_all0  = 1'b1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      w_dig = r_q[4*d +: 4];
      if (w_dig != 4'd9) w_all9 = 1'b0;
      if (w_dig != 4'd0) w_all0 = 1'b0;
      if (w_carry) begin
        if (up_dn) begin
          if (w_dig == 4'd9) begin
            w_step[4*d +: 4] = 4'd0;
          end else begin
            w_step[4*d +: 4] = w_dig + 4'd1;
            w_carry          = 1'b0;
          end
        end else begin
          if (w_dig == 4'd0) begin
            w_step[4*d +: 4] = 4'd9;
          end else begin
            w_step[4*d +: 4] = w_dig - 4'd1;
            w_carry          = 1'b0;
          end
        end
      end
    end
  end

  // Replace any non-BCD load digit with 0 and flag the load as bad.
  always_comb begin
    w_load_san = load_val;
    w_load_bad = 1'b0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (load_val[4*d +: 4] > 4'd9) begin
        w_load_san[4*d +: 4] = 4'd0;
        w_load_bad           = 1'b1;
      end
    end
  end

  // Terminal value depends on the direction requested this cycle.
  always_comb begin
    w_at_term = up_dn ? w_all9 : w_all0;
    TC        = en & ~load & ~reset & w_at_term;
  end

  // Count register and load-error pulse; reset > load > en.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q        <= '0;
      r_load_err <= 1'b0;
    end else if (load) begin
      r_q        <= w_load_san;
      r_load_err <= w_load_bad;
    end else begin
      r_load_err <= 1'b0;
      if (en && !(SATURATE && w_at_term)) r_q <= w_step;
    end
  end

  assign Q        = r_q;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Self-checking bench: a wrap-mode and a saturate-mode counter share stimulus;
// both are checked every cycle against an integer reference model, plus a
// constant vector table and hand-written corner sequences.
module tb_bcd_counter_multi;

  logic        clk;
  logic        reset, en, up_dn, load;
  logic [15:0] load_val;
  logic [15:0] q_w, q_s;
  logic        tc_w, tc_s, err_w, err_s;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: plain integer counts 0..9999.
  int m_w, m_s;
  bit m_err;

  bcd_counter_multi #(.DIGITS(4), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .Q(q_w), .TC(tc_w), .load_err(err_w)
  );

  bcd_counter_multi #(.DIGITS(4), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .Q(q_s), .TC(tc_s), .load_err(err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int load_num(input logic [15:0] lv);
    int v, w;
    logic [3:0] d;
    v = 0;
    w = 1;
    for (int k = 0; k < 4; k++) begin
      d = lv[4*k +: 4];
      if (d <= 4'd9) v = v + int'(d) * w;
      w = w * 10;
    end
    return v;
  endfunction

  function automatic bit load_bad(input logic [15:0] lv);
    bit b;
    logic [3:0] d;
    b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d = lv[4*k +: 4];
      if (d > 4'd9) b = 1'b1;
    end
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_tc(input int m, input bit r, input bit e, input bit u,
                                input bit l);
    return e && !l && !r && (u ? (m == 9999) : (m == 0));
  endfunction

  // One clock: drive, check TC before the edge, advance model, check state after.
  task automatic cyc(input bit r, input bit e, input bit u, input bit l,
                     input logic [15:0] lv, output bit cap_tc_w, output bit cap_tc_s);
    reset = r; en = e; up_dn = u; load = l; load_val = lv;
    #1;
    cap_tc_w = tc_w;
    cap_tc_s = tc_s;
    chk("tc_wrap", {31'd0, tc_w}, {31'd0, exp_tc(m_w, r, e, u, l)});
    chk("tc_sat",  {31'd0, tc_s}, {31'd0, exp_tc(m_s, r, e, u, l)});
    @(posedge clk);
    if (r) begin
      m_w = 0; m_s = 0; m_err = 1'b0;
    end else if (l) begin
      m_w = load_num(lv); m_s = m_w; m_err = load_bad(lv);
    end else begin
      m_err = 1'b0;
      if (e) begin
        if (u) begin
          m_w = (m_w + 1) % 10000;
          if (m_s < 9999) m_s = m_s + 1;
        end else begin
          m_w = (m_w + 9999) % 10000;
          if (m_s > 0) m_s = m_s - 1;
        end
      end
    end
    #1;
    chk("q_wrap",   {16'd0, q_w}, {16'd0, to_bcd(m_w)});
    chk("q_sat",    {16'd0, q_s}, {16'd0, to_bcd(m_s)});
    chk("err_wrap", {31'd0, err_w}, {31'd0, m_err});
    chk("err_sat",  {31'd0, err_s}, {31'd0, m_err});
    @(negedge clk);
  endtask

  typedef struct {
    bit          rst, en, ud, ld;
    logic [15:0] lv;
    bit          tc;   // expected TC of wrap instance during the cycle
    logic [15:0] q;    // expected wrap-instance Q after the edge
    bit          err;
  } vec_t;

  vec_t tbl[17];

  initial begin
    bit t_w, t_s;
    int tc_cnt;
    reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 16'h0;
    m_w = 0; m_s = 0; m_err = 1'b0;
    @(negedge clk);

    // Reset state
    cyc(1, 0, 1, 0, 16'h0, t_w, t_s);
    chk("reset_q", {16'd0, q_w}, 32'h0);
    chk("reset_err", {31'd0, err_w}, 32'd0);

    tbl[0]  = '{0, 1, 0, 0, 16'h0000, 1, 16'h9999, 0};
    tbl[1]  = '{0, 1, 0, 0, 16'h0000, 0, 16'h9998, 0};
    tbl[2]  = '{0, 1, 1, 1, 16'h3A7F, 0, 16'h3070, 1};
    tbl[3]  = '{0, 0, 1, 0, 16'h0000, 0, 16'h3070, 0};
    tbl[4]  = '{0, 0, 1, 1, 16'h1234, 0, 16'h1234, 0};
    tbl[5]  = '{0, 0, 1, 1, 16'h0999, 0, 16'h0999, 0};
    tbl[6]  = '{0, 1, 1, 0, 16'h0000, 0, 16'h1000, 0};
    tbl[7]  = '{0, 1, 0, 0, 16'h0000, 0, 16'h0999, 0};
    tbl[8]  = '{0, 0, 0, 1, 16'h1000, 0, 16'h1000, 0};
    tbl[9]  = '{0, 1, 0, 0, 16'h0000, 0, 16'h0999, 0};
    tbl[10] = '{0, 0, 1, 1, 16'h4567, 0, 16'h4567, 0};
    tbl[11] = '{0, 1, 1, 0, 16'h0000, 0, 16'h4568, 0};
    tbl[12] = '{1, 1, 1, 1, 16'hFFFF, 0, 16'h0000, 0};
    tbl[13] = '{0, 0, 1, 1, 16'h9999, 0, 16'h9999, 0};
    tbl[14] = '{0, 1, 1, 0, 16'h0000, 1, 16'h0000, 0};
    tbl[15] = '{0, 1, 1, 1, 16'h9999, 0, 16'h9999, 0};
    tbl[16] = '{0, 0, 1, 0, 16'h0000, 0, 16'h9999, 0};

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].rst, tbl[i].en, tbl[i].ud, tbl[i].ld, tbl[i].lv, t_w, t_s);
      chk($sformatf("tbl%0d_tc", i), {31'd0, t_w}, {31'd0, tbl[i].tc});
      chk($sformatf("tbl%0d_q", i), {16'd0, q_w}, {16'd0, tbl[i].q});
      chk($sformatf("tbl%0d_err", i), {31'd0, err_w}, {31'd0, tbl[i].err});
    end

    // Saturate: load 9998, up x3, then down once.
    cyc(0, 0, 1, 1, 16'h9998, t_w, t_s);
    cyc(0, 1, 1, 0, 16'h0, t_w, t_s);
    chk("sat1_tc", {31'd0, t_s}, 32'd0);
    chk("sat1_q", {16'd0, q_s}, 32'h9999);
    cyc(0, 1, 1, 0, 16'h0, t_w, t_s);
    chk("sat2_tc", {31'd0, t_s}, 32'd1);
    chk("sat2_q", {16'd0, q_s}, 32'h9999);
    cyc(0, 1, 1, 0, 16'h0, t_w, t_s);
    chk("sat3_tc", {31'd0, t_s}, 32'd1);
    chk("sat3_q", {16'd0, q_s}, 32'h9999);
    cyc(0, 1, 0, 0, 16'h0, t_w, t_s);
    chk("sat_down_q", {16'd0, q_s}, 32'h9998);

    // Saturate at zero going down.
    cyc(0, 0, 0, 1, 16'h0000, t_w, t_s);
    cyc(0, 1, 0, 0, 16'h0, t_w, t_s);
    chk("sat0_tc", {31'd0, t_s}, 32'd1);
    chk("sat0_q", {16'd0, q_s}, 32'h0000);

    // Full count-up sweep from reset on the wrap instance.
    cyc(1, 0, 1, 0, 16'h0, t_w, t_s);
    tc_cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      cyc(0, 1, 1, 0, 16'h0, t_w, t_s);
      if (t_w) tc_cnt++;
    end
    chk("sweep_tc_count", tc_cnt, 32'd1);
    chk("sweep_end_q", {16'd0, q_w}, 32'h0000);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit r, e, u, l;
      logic [15:0] lv;
      r  = ($urandom_range(0, 99) < 2);
      l  = ($urandom_range(0, 99) < 8);
      e  = ($urandom_range(0, 99) < 85);
      u  = $urandom_range(0, 1) == 1;
      lv = 16'($urandom);
      if ($urandom_range(0, 3) != 0) lv = to_bcd(int'($urandom_range(0, 9999)));
      if ($urandom_range(0, 9) == 0) lv = ($urandom_range(0, 1) == 1) ? 16'h9999 : 16'h0000;
      cyc(r, e, u, l, lv, t_w, t_s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_counter_multi.md
Name: bcd_counter_multi

Overview:
- Parametrised multi-digit BCD up/down counter. Next generation of the single-digit BCD counter used in the display and timekeeping paths.
- Adds configurable digit count, up/down direction, parallel load with digit validation, and a selectable wrap or saturate mode.
- Feeds seven-segment decoders directly; a cascade of instances chains via TC into en.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); Q width is 4*DIGITS.
- SATURATE, 0, 0 = wrap at terminal value, 1 = hold at terminal value.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up_dn  input  1  1 = count up, 0 = count down; sampled each enabled cycle.
- load  input  1  synchronous parallel load strobe.
- load_val  input  4*DIGITS  packed BCD load value; digit 0 is in [3:0].
- Q  output  4*DIGITS  packed BCD count, registered.
- TC  output  1  terminal count, combinational.
- load_err  output  1  registered one-cycle pulse after a load that contained an invalid digit.

Behaviour:
- Clocking: single clock. All state updates on the rising edge of clk. reset is synchronous, active-high.
- Reset: Q = 0 (all digits 0), load_err = 0. reset has priority over load and en.
- Priority: reset > load > en. With en = 0 and load = 0, Q holds.
- Load:
  - Q takes load_val on the next edge, regardless of en.
  - Any load_val digit > 9 is replaced by 0 in Q. load_err pulses high for exactly the cycle after that load.
  - load_err is 0 after a valid load and in all non-load cycles.
- Count up (en = 1, up_dn = 1):
  - Digit 0 increments. A digit at 9 rolls to 0 and carries into the next digit; the carry chain is evaluated combinationally within one cycle.
  - All digits 9 (terminal): SATURATE = 0 gives Q = 0 on the next edge; SATURATE = 1 holds Q.
- Count down (en = 1, up_dn = 0):
  - Digit 0 decrements. A digit at 0 rolls to 9 and borrows from the next digit.
  - All digits 0 (terminal): SATURATE = 0 gives Q = all 9s; SATURATE = 1 holds Q.
- TC:
  - TC = en AND NOT load AND NOT reset AND (up_dn ? Q == all 9s : Q == all 0s).
  - Asserts in the same cycle as the terminal value, in both modes, so cascaded instances advance on the wrap edge.
  - In SATURATE mode TC stays high for every enabled cycle at terminal.
- Latency: one clock from en/load to the new Q. TC has zero latency from Q, en and up_dn.
- Direction change: up_dn may toggle on any cycle. Each cycle uses that cycle's up_dn value; there is no pipeline and no skipped step.
- Invariant: Q digits are always in 0..9. Invalid BCD can never appear on Q.
- Mid-count reset: reset on any cycle gives Q = 0 on the next edge. TC is forced low while reset is high.
- Load with en high: load wins. Q = load_val (sanitised), no increment is applied that cycle, and TC = 0.

Test Plan:
- Reset then count up, DIGITS=4, SATURATE=0: en high 10000 cycles -> Q steps 0000..9999 in BCD; TC high only in the cycle Q=9999; Q=0000 after the next edge.
- Count down from 0000, SATURATE=0: one enabled cycle with up_dn=0 -> TC high while Q=0000; next Q=9999; then 9998.
- Saturate mode: load 9998, count up 3 cycles -> Q = 9999, 9999, 9999; TC high for the 2nd and 3rd cycles. Then up_dn=0 for 1 cycle -> Q=9998.
- Load validation: load_val=0x3A7F with en=1 -> Q=0x3070 next edge; load_err high exactly one cycle; TC=0 during the load cycle. A later load of 0x1234 -> load_err=0.
- Carry/borrow chain: load 0x0999, up 1 cycle -> 0x1000; down 1 cycle -> 0x0999. Load 0x1000, down -> 0x0999.
- Reset mid-operation: counting up at 0x4567, reset asserted with load=1 -> Q=0000 next edge, load_err=0, TC=0 during reset.
